ps2_scan_receiver: RTL and testbench
====================================

// Module: ps2_scan_receiver
// PURPOSE
//  Receives PS/2 keyboard frames on the raw ps2_clk/ps2_data pins and decodes them to 8-bit scan codes.
//  Each valid code is presented on keyboardCode with a one-cycle ps2_ready strobe.
//  Sits between the board PS/2 connector and the Pac-Man direction controller.
//  Produces the keyboardCode/ps2_ready pair that the controller consumes (e.g. 0x6B/0x74/0x75/0x72 = L/R/U/D).
// PARAMETERS
//  SYNC_STAGES     2      flops per pin synchronizer (>=2)
//  TIMEOUT_CYCLES  50000  clk cycles with no ps2_clk falling edge before a partial frame is aborted
// PORTS
//  clk           in   1  system clock; sole clock domain
//  rst           in   1  asynchronous, active-low reset
//  ps2_clk       in   1  raw PS/2 clock pin, asynchronous to clk
//  ps2_data      in   1  raw PS/2 data pin, asynchronous to clk
//  keyboardCode  out  8  last accepted scan code; held until the next accept
//  ps2_ready     out  1  one-clk pulse: keyboardCode updated this cycle
//  ext           out  1  code was preceded by 0xE0; valid with ps2_ready; 0 when the macro is off
//  frame_err     out  1  one-clk pulse: parity/stop error or timeout abort
// BEHAVIOUR
//  Reset
//   - Async on rst==0.
//   - keyboardCode=0, ps2_ready=0, ext=0, frame_err=0.
//   - FSM=IDLE; bit counter, timeout counter and prefix flags cleared; synchronizers preset to 1.
//   - rst asserted mid-frame discards the partial frame; no strobe follows.
//  Sampling
//   - Both pins pass through SYNC_STAGES flops.
//   - A falling edge is synced ps2_clk going 1->0 between consecutive clk cycles.
//   - Data is sampled on the clk where the edge is detected.
//  Frame: start(0), d0..d7 LSB first, odd parity, stop(1) = 11 falling edges.
//  FSM states IDLE, SHIFT, CHECK
//   - IDLE: on an edge with data==0, go to SHIFT with count=1. An edge with data==1 is ignored and the FSM stays in IDLE.
//   - SHIFT: each edge shifts data in and increments count. When count reaches 11, go to CHECK.
//   - SHIFT: the timeout counter clears on every edge. When it reaches TIMEOUT_CYCLES, pulse frame_err and go to IDLE.
//   - CHECK: lasts 1 cycle, then returns to IDLE.
//      - If ^{d,parity}==1 and stop==1, the byte is accepted.
//      - Otherwise pulse frame_err and drop the byte.
//  Output latency: ps2_ready asserts on the clk after the 11th edge is detected, i.e. the CHECK cycle.
//  Strobe and error rules
//   - ps2_ready and frame_err are never high together.
//   - keyboardCode changes only on the cycle ps2_ready is high.
//  Back-to-back frames need no gap; the consumer must not stall (no backpressure).
// CONFIGURATION
//  Macro PS2_BREAK_FILTER_EN
//  Defined
//   - An accepted 0xE0 sets pend_ext and an accepted 0xF0 sets pend_brk; neither pulses ps2_ready.
//   - Next accepted non-prefix byte, pend_brk==1: suppressed (key release), no ps2_ready.
//   - Next accepted non-prefix byte, pend_brk==0: ps2_ready pulses with ext=pend_ext.
//   - Both flags clear after that byte.
//   - Both flags also clear on frame_err.
//  Undefined
//   - Every accepted byte, including 0xE0 and 0xF0, pulses ps2_ready.
//   - ext is tied to 0.
// TESTING
//  1. Send frame 0x6B (bits 1,1,0,1,0,1,1,0, parity 0, stop 1) -> keyboardCode=0x6B; ps2_ready high exactly 1 clk, ext=0.
//  2. Send 0x75 with parity forced to 1 -> frame_err 1 clk; no ps2_ready; keyboardCode keeps its prior value.
//  3. Send start + 4 data bits, then idle TIMEOUT_CYCLES -> frame_err pulse; a following full 0x72 frame decodes to keyboardCode=0x72.
//  4. Macro on: F0,6B -> no ps2_ready. Then E0,74 -> one ps2_ready with keyboardCode=0x74, ext=1.
//  5. Macro off: F0,6B -> two ps2_ready pulses, keyboardCode=0xF0 then 0x6B, ext=0.
//  6. Drop rst low after 6 edges of a 0x74 frame, release, send 0x6B -> only one ps2_ready, keyboardCode=0x6B.

Source files
------------

// File: rtl/ps2_scan_receiver_if.sv
// Scan-code output bundle of the PS/2 receiver.
// The receiver drives it through the master modport. The direction controller reads it through the slave modport.
interface ps2_scan_receiver_if;
  logic [7:0] keyboardCode;
  logic       ps2_ready;
  logic       ext;
  logic       frame_err;

  modport master (output keyboardCode, ps2_ready, ext, frame_err);
  modport slave  (input  keyboardCode, ps2_ready, ext, frame_err);
endinterface

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard frame receiver.
// It synchronises the raw ps2_clk and ps2_data pins and detects falling edges of ps2_clk.
// It decodes 11-bit frames: start, 8 data bits LSB first, odd parity, stop.
// Each accepted code is presented with a one-cycle ps2_ready strobe.
// Optional feature: macro PS2_BREAK_FILTER_EN.
//   - It swallows the E0 and F0 prefixes.
//   - It suppresses break (key release) codes.
//   - It flags extended codes on ext.
// When the macro is undefined, every accepted byte is strobed and ext stays 0.
module ps2_scan_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  ps2_scan_receiver_if.master kb
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [8:0]             sh_q, sh_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [7:0]             code_q, code_d;
  logic                   ready_q, ready_d;
  logic                   ext_q, ext_d;
  logic                   err_q, err_d;
`ifdef PS2_BREAK_FILTER_EN
  logic                   pend_ext_q, pend_ext_d;
  logic                   pend_brk_q, pend_brk_d;
`endif

  logic fall;
  logic bit_s;
  logic frame_done;
  logic frame_ok;
  logic timeout_hit;

  // Pin synchronisers and falling-edge detection on the synchronised PS/2 clock
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
    fall        = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    bit_s       = data_sync_q[SYNC_STAGES-1];
  end

  // State register: every flop of the block, preset on asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      tmo_q       <= '0;
      code_q      <= '0;
      ready_q     <= 1'b0;
      ext_q       <= 1'b0;
      err_q       <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      pend_ext_q  <= 1'b0;
      pend_brk_q  <= 1'b0;
`endif
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      tmo_q       <= tmo_d;
      code_q      <= code_d;
      ready_q     <= ready_d;
      ext_q       <= ext_d;
      err_q       <= err_d;
`ifdef PS2_BREAK_FILTER_EN
      pend_ext_q  <= pend_ext_d;
      pend_brk_q  <= pend_brk_d;
`endif
    end
  end

  // Next-state logic: frame sequencing, bit shifting and inactivity timeout
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    tmo_d       = tmo_q;
    frame_done  = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      // CHECK also accepts a start bit so back-to-back frames need no gap
      IDLE, CHECK: begin
        state_d = IDLE;
        tmo_d   = '0;
        if (fall && !bit_s) begin
          state_d = SHIFT;
          cnt_d   = 4'd1;
        end
      end
      SHIFT: begin
        if (fall) begin
          tmo_d = '0;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd10) begin
            // The 11th edge carries the stop bit; sh_q already holds d0..d7 and parity
            frame_done = 1'b1;
            state_d    = CHECK;
          end else begin
            sh_d = {bit_s, sh_q[8:1]};
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          tmo_d       = '0;
          state_d     = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: accept or reject the completed frame and apply the prefix filter
  always_comb begin
    frame_ok = frame_done & (^sh_q) & bit_s;
    code_d   = code_q;
    ready_d  = 1'b0;
    ext_d    = 1'b0;
    err_d    = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    pend_ext_d = pend_ext_q;
    pend_brk_d = pend_brk_q;
`endif
    if (timeout_hit || (frame_done && !frame_ok)) begin
      err_d = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
      pend_ext_d = 1'b0;
      pend_brk_d = 1'b0;
`endif
    end else if (frame_ok) begin
`ifdef PS2_BREAK_FILTER_EN
      if (sh_q[7:0] == 8'hE0) begin
        pend_ext_d = 1'b1;
      end else if (sh_q[7:0] == 8'hF0) begin
        pend_brk_d = 1'b1;
      end else begin
        if (!pend_brk_q) begin
          ready_d = 1'b1;
          code_d  = sh_q[7:0];
          ext_d   = pend_ext_q;
        end
        pend_ext_d = 1'b0;
        pend_brk_d = 1'b0;
      end
`else
      ready_d = 1'b1;
      code_d  = sh_q[7:0];
`endif
    end
  end

  assign kb.keyboardCode = code_q;
  assign kb.ps2_ready    = ready_q;
  assign kb.ext          = ext_q;
  assign kb.frame_err    = err_q;
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Randomised bench for ps2_scan_receiver, checked against a byte-level reference model.
// Directed cases run first, followed by random frames with parity, stop and timeout faults.
module tb_ps2_scan_receiver;
  localparam int TMO = 300;
`ifdef PS2_BREAK_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk;
  logic rst;
  logic ps2_clk;
  logic ps2_data;

  ps2_scan_receiver_if kb_if ();

  ps2_scan_receiver #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .kb      (kb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: last presented code and pending prefix flags
  logic [7:0] m_code = 8'h00;
  bit         m_ext  = 1'b0;
  bit         m_brk  = 1'b0;

  // Events observed on the output bundle: kind 1 = ready, 2 = error
  int         obs_kind[$];
  logic [7:0] obs_code[$];
  logic       obs_ext[$];
  logic [7:0] prev_code = 8'h00;

  always @(negedge clk) begin
    if (kb_if.ps2_ready || kb_if.frame_err) begin
      check_val("no_overlap", 32'(kb_if.ps2_ready & kb_if.frame_err), 0);
      obs_kind.push_back(kb_if.ps2_ready ? 1 : 2);
      obs_code.push_back(kb_if.keyboardCode);
      obs_ext.push_back(kb_if.ext);
    end
    if (rst && (kb_if.keyboardCode !== prev_code))
      check_val("code_chg_w_ready", 32'(kb_if.ps2_ready), 1);
    prev_code = kb_if.keyboardCode;
  end

  // Expected outcome of one complete frame: ek 0 = nothing, 1 = ready, 2 = error
  task automatic model_frame(input logic [7:0] b, input bit good,
                             output int ek, output logic [7:0] ec, output bit ee);
    ek = 0; ec = m_code; ee = 1'b0;
    if (!good) begin
      ek = 2; m_ext = 1'b0; m_brk = 1'b0;
    end else if (!FILT) begin
      ek = 1; ec = b; m_code = b;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (!m_brk) begin
        ek = 1; ec = b; ee = m_ext; m_code = b;
      end
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic b, input int half);
    ps2_data = b;
    repeat (half) @(posedge clk);
    #2 ps2_clk = 1'b0;
    repeat (half) @(posedge clk);
    #2 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bp, input bit bs,
                            input int nbits, input int half);
    logic [10:0] fb;
    fb[0]   = 1'b0;
    fb[8:1] = b;
    fb[9]   = ~(^b) ^ bp;
    fb[10]  = ~bs;
    for (int i = 0; i < nbits; i++) ps2_bit(fb[i], half);
    ps2_data = 1'b1;
  endtask

  task automatic clear_obs();
    obs_kind.delete();
    obs_code.delete();
    obs_ext.delete();
  endtask

  task automatic compare_obs(input string name, input int ek, input logic [7:0] ec, input bit ee);
    check_val({name, ".events"}, 32'(obs_kind.size()), (ek == 0) ? 0 : 1);
    if (ek != 0 && obs_kind.size() > 0) begin
      check_val({name, ".kind"}, 32'(obs_kind[0]), 32'(ek));
      if (ek == 1) begin
        check_val({name, ".code"}, 32'(obs_code[0]), 32'(ec));
        check_val({name, ".ext"}, 32'(obs_ext[0]), 32'(ee));
      end
    end
    check_val({name, ".code_hold"}, 32'(kb_if.keyboardCode), 32'(m_code));
    $display("txn %-10s events=%0d expect_kind=%0d code=%02h ext=%0d", name,
             obs_kind.size(), ek, kb_if.keyboardCode, kb_if.ext);
  endtask

  task automatic run_frame(input string name, input logic [7:0] b, input bit bp, input bit bs);
    int ek; logic [7:0] ec; bit ee;
    model_frame(b, !bp && !bs, ek, ec, ee);
    clear_obs();
    send_frame(b, bp, bs, 11, $urandom_range(4, 10));
    repeat (20) @(posedge clk);
    @(negedge clk);
    compare_obs(name, ek, ec, ee);
  endtask

  task automatic run_partial(input string name, input logic [7:0] b, input int nbits);
    clear_obs();
    m_ext = 1'b0; m_brk = 1'b0;
    send_frame(b, 1'b0, 1'b0, nbits, $urandom_range(4, 10));
    repeat (TMO + 40) @(posedge clk);
    @(negedge clk);
    compare_obs(name, 2, m_code, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("rst.code", 32'(kb_if.keyboardCode), 0);
    check_val("rst.ready", 32'(kb_if.ps2_ready), 0);
    check_val("rst.ext", 32'(kb_if.ext), 0);
    check_val("rst.err", 32'(kb_if.frame_err), 0);
    rst = 1'b1;
    repeat (5) @(posedge clk);

    run_frame("t1_6B", 8'h6B, 1'b0, 1'b0);
    run_frame("t2_par", 8'h75, 1'b1, 1'b0);
    run_frame("stop_err", 8'h1C, 1'b0, 1'b1);
    run_partial("t3_tmo", 8'h33, 5);
    run_frame("t3_72", 8'h72, 1'b0, 1'b0);

    // Stray clock pulse with data high while idle: must be ignored
    clear_obs();
    ps2_bit(1'b1, 6);
    repeat (20) @(posedge clk);
    @(negedge clk);
    compare_obs("stray", 0, m_code, 1'b0);

    run_frame("brk_F0", 8'hF0, 1'b0, 1'b0);
    run_frame("brk_6B", 8'h6B, 1'b0, 1'b0);
    run_frame("ext_E0", 8'hE0, 1'b0, 1'b0);
    run_frame("ext_74", 8'h74, 1'b0, 1'b0);

    // Reset in the middle of a frame discards it
    clear_obs();
    send_frame(8'h74, 1'b0, 1'b0, 6, 6);
    #3 rst = 1'b0;
    m_code = 8'h00; m_ext = 1'b0; m_brk = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    compare_obs("t6_rst", 0, m_code, 1'b0);
    run_frame("t6_6B", 8'h6B, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      r = $urandom_range(0, 11);
      b = 8'($urandom);
      if (r < 2) b = 8'hE0;
      else if (r < 4) b = 8'hF0;
      if (r == 11) run_partial("rnd_tmo", b, $urandom_range(1, 10));
      else run_frame("rnd", b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
